pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage ARM core. It sits beside the decode stage and drives the freeze, bubble and flush controls of the IF, ID and ID/EX registers. It resolves three things: read-after-write data hazards on decode sources, taken-branch flushes from EXE, and multi-cycle SRAM waits from MEM. A stall timeout and saturating performance counters support debug.

---
 rtl/arm_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared definitions for the ARM core pipeline control blocks.
//   - ctrl_state_e : sequencing FSM states (RUN / MEM_WAIT / HALT)
//   - REG_IDX_W    : register-file index width
//   - CNT_W_DEF    : default performance-counter width
package arm_pkg;

    localparam int unsigned REG_IDX_W = 4;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned CNT_W_DEF = 16;

    // Encoding 2'd3 is unused and recovers to RUN.
    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_e;

endpackage : arm_pkg

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk_i  : clock
//   clr_i  : synchronous clear (wins over increment)
//   inc_i  : add one this cycle
//   cnt_o  : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencing controller beside the decode stage.
// Resolves RAW data hazards on decode sources, taken-branch flushes from EXE
// and multi-cycle SRAM waits from MEM, with a wait timeout and saturating
// performance counters.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   id_valid, src1/src1_used,
//   src2/two_src                     : decode-stage sources
//   exe_dest/exe_wb_en/exe_mem_r     : EXE-stage producer
//   mem_dest/mem_wb_en               : MEM-stage producer
//   fwd_en                           : forwarding unit active
//   branch_taken                     : EXE resolved a taken branch
//   mem_req/mem_ready                : MEM access handshake with SRAM ctrl
//   pc_freeze, ifid_freeze,
//   idex_bubble, ifid_flush,
//   idex_flush, pipe_freeze          : combinational pipeline controls
//   mem_err                          : sticky timeout flag
//   state                            : FSM state
//   stall_cnt/flush_cnt/wait_cnt     : saturating performance counters
module pipe_hazard_ctrl
    import arm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] src1,
    input  logic                 src1_used,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 fwd_en,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_freeze,
    output logic                 ifid_freeze,
    output logic                 idex_bubble,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 pipe_freeze,
    output logic                 mem_err,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     wait_cnt
);

    localparam int unsigned TMR_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic [TMR_W-1:0] tmr_inc;
    logic             err_q;
    logic             err_d;

    logic             exe_match;
    logic             mem_match;
    logic             hazard;
    logic             mem_frz;
    logic             halted;
    logic             legal;
    logic             wait_inc;

    // Source/destination matches against the two in-flight producers.
    always_comb begin
        exe_match = exe_wb_en &&
                    ((src1_used && (src1 == exe_dest)) ||
                     (two_src   && (src2 == exe_dest)));
        mem_match = mem_wb_en &&
                    ((src1_used && (src1 == mem_dest)) ||
                     (two_src   && (src2 == mem_dest)));
        // With forwarding only a load in EXE cannot be bypassed in time.
        if (fwd_en) begin
            hazard = id_valid && exe_mem_r && exe_match;
        end else begin
            hazard = id_valid && (exe_match || mem_match);
        end
    end

    assign tmr_inc = tmr_q + TMR_W'(1);

    // Next-state logic and prioritised control outputs.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        err_d       = err_q;
        mem_frz     = 1'b0;
        halted      = 1'b0;
        legal       = 1'b1;
        pc_freeze   = 1'b0;
        ifid_freeze = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    mem_frz = 1'b1;
                    state_d = MEM_WAIT;
                    tmr_d   = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    mem_frz = 1'b1;
                    tmr_d   = tmr_inc;
                    if (tmr_inc >= TMR_W'(MEM_TIMEOUT)) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                legal   = 1'b0;
                state_d = RUN;
            end
        endcase

        // Only the highest-priority active class drives its outputs.
        if (halted) begin
            pipe_freeze = 1'b1;
            pc_freeze   = 1'b1;
        end else if (mem_frz) begin
            pipe_freeze = 1'b1;
        end else if (legal && branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (legal && hazard) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idex_bubble = 1'b1;
        end

        // Reset silences every control in the same cycle.
        if (rst) begin
            pc_freeze   = 1'b0;
            ifid_freeze = 1'b0;
            idex_bubble = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            pipe_freeze = 1'b0;
        end
    end

    // State, timer and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    assign state    = state_q;
    assign mem_err  = err_q;
    assign wait_inc = mem_frz && !rst;

    // idex_bubble and ifid_flush are each owned by exactly one output class.
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (idex_bubble),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (ifid_flush),
        .cnt_o (flush_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
        .clk_i (clk),
        .clr_i (rst),
        .inc_i (wait_inc),
        .cnt_o (wait_cnt)
    );

endmodule : pipe_hazard_ctrl
